bcd_seg_display: RTL and testbench

Sequential, parametrised binary-to-decimal display driver. It converts a WIDTH-bit unsigned value into DIGITS BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock. It drives DIGITS active-low seven-segment displays, with optional leading-zero blanking. It generalises the team's 4-bit, two-digit combinational decimal display path to arbitrary widths, with a start/done handshake and registered outputs.

---
 rtl/bcd_seg_display_if.sv | 23 ++
 rtl/bcd_seg_display.sv | 171 +++++++++++++++++
 tb/tb_bcd_seg_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg_display_if.sv
// Conversion request/result bundle for bcd_seg_display.
//   start : request conversion of bin (requester -> converter)
//   bin   : WIDTH-bit unsigned value to convert
//   busy  : conversion in progress
//   done  : one-cycle pulse, bcd/hex refreshed
//   bcd   : packed BCD result, digit 0 in [3:0]
//   hex   : active-low segments, digit k in [7k+6:7k], order g..a
interface bcd_seg_display_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   hex;

  modport master (output start, output bin,
                  input  busy,  input  done, input bcd, input hex);
  modport slave  (input  start, input  bin,
                  output busy,  output done, output bcd, output hex);
endinterface

// File: rtl/bcd_seg_display.sv
// Sequential binary-to-decimal seven-segment driver.
// Converts a WIDTH-bit value to DIGITS BCD digits by shift-and-add-3,
// one bit per clock, then registers the BCD digits and active-low
// segment patterns (optional leading-zero blanking).
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : slave side of bcd_seg_display_if (start/bin in,
//            busy/done/bcd/hex out, all outputs registered)
module bcd_seg_display #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             resetn,
  bcd_seg_display_if.slave bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned HW = 7 * DIGITS;
  localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  // True when DIGITS decimal digits can hold 2^w - 1.
  function automatic bit digits_ok(input int unsigned w, input int unsigned d);
    longint unsigned p;
    longint unsigned maxv;
    p    = 64'd1;
    maxv = (64'd1 << w) - 64'd1;
    for (int unsigned i = 0; i < d && p <= maxv; i++) p = p * 64'd10;
    return p > maxv;
  endfunction

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("bcd_seg_display: WIDTH must be 1..32");
  end
  if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
    $error("bcd_seg_display: DIGITS too small for WIDTH");
  end

  // One BCD digit to active-low g..a pattern.
  function automatic logic [6:0] seg_f(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Full segment word; walks down from the top digit tracking whether
  // every digit seen so far is zero. Digit 0 is always shown.
  function automatic logic [HW-1:0] hex_f(input logic [BW-1:0] v);
    logic [HW-1:0] h;
    logic          lead;
    h    = '0;
    lead = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if ((BLANK_LZ != 0) && lead && (v[4*k +: 4] == 4'd0))
        h[7*k +: 7] = 7'h7F;
      else
        h[7*k +: 7] = seg_f(v[4*k +: 4]);
      lead = lead && (v[4*k +: 4] == 4'd0);
    end
    h[6:0] = seg_f(v[3:0]);
    return h;
  endfunction

  localparam logic [HW-1:0] HEX_RST = hex_f({BW{1'b0}});

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BW-1:0]    r_bcd;
  logic [HW-1:0]    r_hex;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [BW-1:0]    w_work_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [BW-1:0]    w_bcd_nxt;
  logic [HW-1:0]    w_hex_nxt;
  logic [BW-1:0]    w_adj;

  // Add-3 correction: each digit >= 5 gets +3, no carry between digits.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_hex_nxt   = r_hex;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_bin_nxt   = bus.bin;
          w_work_nxt  = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {w_work_nxt, w_bin_nxt} = {w_adj, r_bin} << 1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_bcd_nxt   = r_work;
        w_hex_nxt   = hex_f(r_work);
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_hex   <= HEX_RST;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_bcd   <= w_bcd_nxt;
      r_hex   <= w_hex_nxt;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
  assign bus.hex  = r_hex;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed bench for bcd_seg_display: two 8-bit/3-digit instances
// (blanking on and off) driven in lock-step, plus a 4-bit/2-digit
// instance swept over its whole input range.
module tb_bcd_seg_display;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start8;
  logic [7:0] bin8;
  logic       start4;
  logic [3:0] bin4;

  int n_tests = 0;
  int n_fail  = 0;
  int hist [30];

  logic [6:0] seg_t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  bcd_seg_display_if #(.WIDTH(8), .DIGITS(3)) ifa ();
  bcd_seg_display_if #(.WIDTH(8), .DIGITS(3)) ifb ();
  bcd_seg_display_if #(.WIDTH(4), .DIGITS(2)) ifc ();

  assign ifa.start = start8;
  assign ifa.bin   = bin8;
  assign ifb.start = start8;
  assign ifb.bin   = bin8;
  assign ifc.start = start4;
  assign ifc.bin   = bin4;

  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u_dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa));
  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u_dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb));
  bcd_seg_display #(.WIDTH(4), .DIGITS(2), .BLANK_LZ(1)) u_dut_c (
    .clk(clk), .resetn(resetn), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic hex_a(input string tag, input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
    chk({tag, "_a_hex2"}, 32'(ifa.hex[20:14]), 32'(h2));
    chk({tag, "_a_hex1"}, 32'(ifa.hex[13:7]),  32'(h1));
    chk({tag, "_a_hex0"}, 32'(ifa.hex[6:0]),   32'(h0));
  endtask

  task automatic hex_b(input string tag, input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
    chk({tag, "_b_hex2"}, 32'(ifb.hex[20:14]), 32'(h2));
    chk({tag, "_b_hex1"}, 32'(ifb.hex[13:7]),  32'(h1));
    chk({tag, "_b_hex0"}, 32'(ifb.hex[6:0]),   32'(h0));
  endtask

  // One start pulse on the 8-bit pair; returns #1 after the done edge.
  task automatic conv8(input string tag, input logic [7:0] v);
    int lat;
    @(negedge clk);
    bin8   = v;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    bin8   = ~v;
    chk({tag, "_busy_e0"}, 32'(ifa.busy), 32'd1);
    lat = 0;
    while (ifa.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"},   32'(lat),      32'd9);
    chk({tag, "_busy_done"}, 32'(ifa.busy), 32'd0);
    chk({tag, "_bcd_a"},     32'(ifa.bcd),  32'(dec3(int'(v))));
    chk({tag, "_bcd_b"},     32'(ifb.bcd),  32'(dec3(int'(v))));
  endtask

  initial begin
    int lat;
    int seen;
    resetn = 1'b0;
    start8 = 1'b0;
    bin8   = '0;
    start4 = 1'b0;
    bin4   = '0;
    repeat (2) @(negedge clk);

    chk("rst_bcd", 32'(ifa.bcd),  32'h0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    hex_a("rst", 7'h7F, 7'h7F, 7'h40);
    hex_b("rst", 7'h40, 7'h40, 7'h40);
    chk("rst_c_hex", 32'(ifc.hex), 32'({7'h7F, 7'h40}));
    resetn = 1'b1;

    conv8("v255", 8'd255);
    hex_a("v255", 7'h24, 7'h12, 7'h12);
    hex_b("v255", 7'h24, 7'h12, 7'h12);
    @(posedge clk); #1;
    chk("v255_done_width", 32'(ifa.done), 32'd0);

    conv8("v7", 8'd7);
    hex_a("v7", 7'h7F, 7'h7F, 7'h78);
    hex_b("v7", 7'h40, 7'h40, 7'h78);

    conv8("v100", 8'd100);
    hex_a("v100", 7'h79, 7'h40, 7'h40);
    hex_b("v100", 7'h79, 7'h40, 7'h40);

    conv8("v0", 8'd0);
    hex_a("v0", 7'h7F, 7'h7F, 7'h40);
    hex_b("v0", 7'h40, 7'h40, 7'h40);

    // start held high, bin changing every cycle
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start8  = 1'b1;
      bin8    = 8'((k * 37 + 11) % 256);
      hist[k] = int'(bin8);
      @(posedge clk); #1;
      chk("stream_done", 32'(ifa.done), 32'(k % 10 == 9));
      if (k % 10 == 9) chk("stream_bcd", 32'(ifa.bcd), 32'(dec3(hist[k - 9])));
    end
    @(negedge clk);
    start8 = 1'b0;

    // abort a conversion with reset
    @(negedge clk);
    bin8   = 8'd200;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_bcd",  32'(ifa.bcd),  32'h0);
    chk("abort_busy", 32'(ifa.busy), 32'd0);
    chk("abort_done", 32'(ifa.done), 32'd0);
    hex_a("abort", 7'h7F, 7'h7F, 7'h40);
    hex_b("abort", 7'h40, 7'h40, 7'h40);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ifa.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    conv8("v42", 8'd42);
    hex_a("v42", 7'h7F, 7'h19, 7'h24);
    hex_b("v42", 7'h40, 7'h19, 7'h24);

    // 4-bit, 2-digit exhaustive sweep
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      bin4   = 4'(v);
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = 0;
      while (ifc.done !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w4_latency", 32'(lat), 32'd5);
      chk("w4_bcd", 32'(ifc.bcd), 32'({4'(v / 10), 4'(v % 10)}));
      chk("w4_hex0", 32'(ifc.hex[6:0]), 32'(seg_t[v % 10]));
      chk("w4_hex1", 32'(ifc.hex[13:7]), (v < 10) ? 32'h7F : 32'h79);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
